// File: rtl/write_channel_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module : write_channel_axi_pkg
// Brief  : AXI encodings and engine state codes shared by the write channel.
// Rev    : 1.0
// ============================================================================
package write_channel_axi_pkg;

    localparam logic [1:0] C_BURST_INCR  = 2'b01;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [3:0] C_AWCACHE     = 4'b0011;

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_ADDR = 2'd1;
    localparam state_t C_ST_DATA = 2'd2;
    localparam state_t C_ST_RESP = 2'd3;

    // Width of an index that may legitimately have zero bits.
    function automatic int max1(input int v);
        return (v > 0) ? v : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_channel_axi_beat.sv
`default_nettype none
// ============================================================================
// Module : write_channel_axi_beat
// Brief  : Beat index into the write-back buffer; constant 0 for one-beat lines.
// Rev    : 1.0
// ============================================================================
module write_channel_axi_beat
    import write_channel_axi_pkg::*;
#(
    parameter int LINE2MEM_W = 3,
    parameter int WORD_W     = max1(LINE2MEM_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              adv_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);

    generate
        if (LINE2MEM_W > 0) begin : g_burst
            localparam logic [LINE2MEM_W-1:0] C_LAST = '1;
            localparam logic [LINE2MEM_W-1:0] C_ONE  = 1;

            logic [LINE2MEM_W-1:0] word_q;
            logic [LINE2MEM_W-1:0] word_d;

            // Saturates on the last beat so the index never wraps mid-burst.
            always_comb begin
                word_d = word_q;
                if (clear_i) begin
                    word_d = '0;
                end else if (adv_i && (word_q != C_LAST)) begin
                    word_d = word_q + C_ONE;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign word_o = word_q;
            assign last_o = (word_q == C_LAST);
        end else begin : g_single
            logic w_unused;
            assign w_unused = clk ^ reset ^ clear_i ^ adv_i;
            assign word_o   = '0;
            assign last_o   = 1'b1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/write_channel_axi.sv
`default_nettype none
// ============================================================================
// Module : write_channel_axi
// Brief  : Evicts one cache line as a single AXI4 INCR write burst (AW, W, B).
//          Define AXI_WRITE_RETRY_EN to re-send the burst on an error response.
// Rev    : 1.0
// ============================================================================
module write_channel_axi
    import write_channel_axi_pkg::*;
#(
    parameter int                FE_ADDR_W  = 32,
    parameter int                FE_DATA_W  = 32,
    parameter int                WORD_OFF_W = 3,
    parameter int                BE_ADDR_W  = FE_ADDR_W,
    parameter int                BE_DATA_W  = FE_DATA_W,
    parameter int                BE_NBYTES  = BE_DATA_W / 8,
    parameter int                BE_BYTE_W  = $clog2(BE_NBYTES),
    parameter int                LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
    parameter int                AXI_LEN_W  = 8,
    parameter int                AXI_ID_W   = 1,
    parameter logic [AXI_ID_W-1:0] AXI_ID   = '0
) (
    input  logic                                        clk,
    input  logic                                        reset,

    input  logic                                        wb_valid_i,
    input  logic [FE_ADDR_W-BE_BYTE_W-LINE2MEM_W-1:0]   wb_addr_i,
    output logic                                        wb_ready_o,
    output logic [max1(LINE2MEM_W)-1:0]                 wb_word_o,
    input  logic [BE_DATA_W-1:0]                        wb_wdata_i,

    output logic [AXI_ID_W-1:0]                         m_axi_awid_o,
    output logic [BE_ADDR_W-1:0]                        m_axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]                        m_axi_awlen_o,
    output logic [2:0]                                  m_axi_awsize_o,
    output logic [1:0]                                  m_axi_awburst_o,
    output logic                                        m_axi_awlock_o,
    output logic [3:0]                                  m_axi_awcache_o,
    output logic [2:0]                                  m_axi_awprot_o,
    output logic [3:0]                                  m_axi_awqos_o,
    output logic                                        m_axi_awvalid_o,
    input  logic                                        m_axi_awready_i,

    output logic [BE_DATA_W-1:0]                        m_axi_wdata_o,
    output logic [BE_NBYTES-1:0]                        m_axi_wstrb_o,
    output logic                                        m_axi_wlast_o,
    output logic                                        m_axi_wvalid_o,
    input  logic                                        m_axi_wready_i,

    input  logic [AXI_ID_W-1:0]                         m_axi_bid_i,
    input  logic [1:0]                                  m_axi_bresp_i,
    input  logic                                        m_axi_bvalid_i,
    output logic                                        m_axi_bready_o
);

    localparam int LADDR_W = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W;
    localparam int OFF_W   = LINE2MEM_W + BE_BYTE_W;

    state_t               state_q;
    state_t               state_d;
    logic [LADDR_W-1:0]   addr_q;
    logic [LADDR_W-1:0]   addr_d;
    logic [FE_ADDR_W-1:0] w_line_addr;
    logic                 w_last;
    logic                 w_clear;
    logic                 w_adv;
    logic                 w_resp_ok;
    logic                 w_unused;

    // SLVERR/DECERR both carry bit 1; OKAY and EXOKAY count as success.
    assign w_resp_ok = (m_axi_bresp_i[1] == C_RESP_OKAY[1]);
    assign w_unused  = ^{m_axi_bid_i, m_axi_bresp_i, w_resp_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            C_ST_IDLE: begin
                if (wb_valid_i) begin
                    state_d = C_ST_ADDR;
                    addr_d  = wb_addr_i;
                end
            end
            C_ST_ADDR: begin
                if (m_axi_awready_i) begin
                    state_d = C_ST_DATA;
                end
            end
            C_ST_DATA: begin
                if (m_axi_wready_i && w_last) begin
                    state_d = C_ST_RESP;
                end
            end
            C_ST_RESP: begin
                if (m_axi_bvalid_i) begin
`ifdef AXI_WRITE_RETRY_EN
                    state_d = w_resp_ok ? C_ST_IDLE : C_ST_ADDR;
`else
                    state_d = C_ST_IDLE;
`endif
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        wb_ready_o      = 1'b0;
        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_wlast_o   = 1'b0;
        m_axi_bready_o  = 1'b0;
        case (state_q)
            C_ST_IDLE: wb_ready_o      = 1'b1;
            C_ST_ADDR: m_axi_awvalid_o = 1'b1;
            C_ST_DATA: begin
                m_axi_wvalid_o = 1'b1;
                m_axi_wlast_o  = w_last;
            end
            C_ST_RESP: m_axi_bready_o  = 1'b1;
            default: ;
        endcase
    end

    // Index restarts on every entry to ADDR, including a retried burst.
    assign w_clear = (state_d == C_ST_ADDR) && (state_q != C_ST_ADDR);
    assign w_adv   = (state_q == C_ST_DATA) && m_axi_wready_i;

    write_channel_axi_beat #(
        .LINE2MEM_W (LINE2MEM_W),
        .WORD_W     (max1(LINE2MEM_W))
    ) u_beat (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_clear),
        .adv_i   (w_adv),
        .word_o  (wb_word_o),
        .last_o  (w_last)
    );

    assign w_line_addr     = {addr_q, {OFF_W{1'b0}}};
    assign m_axi_awaddr_o  = BE_ADDR_W'(w_line_addr);
    assign m_axi_awid_o    = AXI_ID;
    assign m_axi_awlen_o   = AXI_LEN_W'((2 ** LINE2MEM_W) - 1);
    assign m_axi_awsize_o  = 3'(BE_BYTE_W);
    assign m_axi_awburst_o = C_BURST_INCR;
    assign m_axi_awlock_o  = 1'b0;
    assign m_axi_awcache_o = C_AWCACHE;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_awqos_o   = 4'b0000;

    assign m_axi_wdata_o   = wb_wdata_i;
    assign m_axi_wstrb_o   = '1;

endmodule
`default_nettype wire

// File: tb/tb_write_channel_axi.sv
`default_nettype none
// ============================================================================
// Module : tb_write_channel_axi
// Brief  : Self-checking bench: 8-beat line (64-bit bus) and single-beat line.
// Rev    : 1.0
// ============================================================================
module tb_write_channel_axi;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---- 8-beat instance: FE 32b, 16 words/line, 64b bus -> LINE2MEM_W=3 ----
    logic        wb_valid, wb_ready;
    logic [25:0] wb_addr;
    logic [2:0]  wb_word;
    logic [63:0] wb_wdata;
    logic [0:0]  awid, bid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, bresp;
    logic        awlock, awvalid, awready;
    logic [3:0]  awcache, awqos;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;
    logic [63:0] bufm [8];
    assign wb_wdata = bufm[wb_word];

    write_channel_axi #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(4), .BE_DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_ready_o(wb_ready),
        .wb_word_o(wb_word), .wb_wdata_i(wb_wdata),
        .m_axi_awid_o(awid), .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen),
        .m_axi_awsize_o(awsize), .m_axi_awburst_o(awburst), .m_axi_awlock_o(awlock),
        .m_axi_awcache_o(awcache), .m_axi_awprot_o(awprot), .m_axi_awqos_o(awqos),
        .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid),
        .m_axi_bready_o(bready));

    // ---- single-beat instance: 256b bus -> LINE2MEM_W=0 ----
    logic         wb_valid1, wb_ready1;
    logic [26:0]  wb_addr1;
    logic [0:0]   wb_word1, awid1, bid1;
    logic [255:0] buf1, wdata1;
    logic [31:0]  awaddr1, wstrb1;
    logic [7:0]   awlen1;
    logic [2:0]   awsize1, awprot1;
    logic [1:0]   awburst1, bresp1;
    logic         awlock1, awvalid1, awready1, wlast1, wvalid1, wready1, bvalid1, bready1;
    logic [3:0]   awcache1, awqos1;

    write_channel_axi #(.FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3), .BE_DATA_W(256)) dut1 (
        .clk(clk), .reset(reset),
        .wb_valid_i(wb_valid1), .wb_addr_i(wb_addr1), .wb_ready_o(wb_ready1),
        .wb_word_o(wb_word1), .wb_wdata_i(buf1),
        .m_axi_awid_o(awid1), .m_axi_awaddr_o(awaddr1), .m_axi_awlen_o(awlen1),
        .m_axi_awsize_o(awsize1), .m_axi_awburst_o(awburst1), .m_axi_awlock_o(awlock1),
        .m_axi_awcache_o(awcache1), .m_axi_awprot_o(awprot1), .m_axi_awqos_o(awqos1),
        .m_axi_awvalid_o(awvalid1), .m_axi_awready_i(awready1),
        .m_axi_wdata_o(wdata1), .m_axi_wstrb_o(wstrb1), .m_axi_wlast_o(wlast1),
        .m_axi_wvalid_o(wvalid1), .m_axi_wready_i(wready1),
        .m_axi_bid_i(bid1), .m_axi_bresp_i(bresp1), .m_axi_bvalid_i(bvalid1),
        .m_axi_bready_o(bready1));

    int n_vec = 0;
    int n_bad = 0;

    // Slave-side responder knobs
    bit rnd_rdy = 1'b0;
    int aw_delay_left = 0;
    int stall_beat = -1;
    int stall_left = 0;
    int err_left = 0;

    always begin
        @(posedge clk); #1;
        if (awvalid && aw_delay_left > 0) begin
            awready = 1'b0; aw_delay_left--;
        end else begin
            awready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (wvalid && int'(wb_word) == stall_beat && stall_left > 0) begin
            wready = 1'b0; stall_left--;
        end else begin
            wready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (bready) begin
            bvalid = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            bresp  = (err_left > 0) ? 2'b10 : 2'b00;
            if (bvalid && err_left > 0) err_left--;
        end else begin
            bvalid = rnd_rdy ? ($urandom_range(0, 4) == 0) : 1'b0;
            bresp  = 2'b00;
        end
    end

    // Monitor: values at negedge decide the handshake of the following posedge.
    logic [31:0] aw_q [$];
    logic [7:0]  len_q [$];
    logic [63:0] wd_q [$];
    bit          wl_q [$];
    int          b_cnt = 0;
    int          proto_bad = 0;
    bit          aw_seen = 1'b0, pa_v = 1'b0, pw_v = 1'b0, pw_last;
    logic [31:0] pa_addr;
    logic [63:0] pw_data;
    logic [2:0]  pw_word;

    always @(negedge clk) begin
        if (reset) begin
            aw_seen = 1'b0; pa_v = 1'b0; pw_v = 1'b0;
        end else begin
            if (wvalid && !aw_seen) proto_bad++;
            if (pa_v && (!awvalid || awaddr != pa_addr)) proto_bad++;
            if (pw_v && (!wvalid || wdata != pw_data || wlast != pw_last || wb_word != pw_word)) proto_bad++;
            pa_v = awvalid && !awready; pa_addr = awaddr;
            pw_v = wvalid && !wready; pw_data = wdata; pw_last = wlast; pw_word = wb_word;
            if (awvalid && awready) begin
                aw_q.push_back(awaddr); len_q.push_back(awlen); aw_seen = 1'b1;
            end
            if (wvalid && wready) begin
                wd_q.push_back(wdata); wl_q.push_back(wlast);
            end
            if (bvalid && bready) begin
                b_cnt++; aw_seen = 1'b0;
            end
        end
    end

    bit aw_at_accept;

    // Issues one eviction request and counts edges after acceptance until free again.
    task automatic do_burst(input logic [25:0] a, output int edges, output bit timeout);
        int w = 0;
        aw_q.delete(); len_q.delete(); wd_q.delete(); wl_q.delete();
        b_cnt = 0; proto_bad = 0;
        while (!wb_ready && w < 300) begin @(posedge clk); #1; w++; end
        wb_valid = 1'b1; wb_addr = a;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        aw_at_accept = awvalid && !wvalid;
        edges = 0;
        while (!wb_ready && edges < 300) begin @(posedge clk); #1; edges++; end
        timeout = !wb_ready;
    endtask

    task automatic fill_buf();
        for (int i = 0; i < 8; i++) bufm[i] = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); end
        n_vec++; if ({awvalid, wvalid, bready} !== 3'b000) begin n_bad++; $display("FAIL reset_valids got=%b exp=000", {awvalid, wvalid, bready}); end
        n_vec++; if (wb_word !== 3'd0) begin n_bad++; $display("FAIL reset_wb_word got=%0d exp=0", wb_word); end
        n_vec++; if (awaddr !== 32'h0) begin n_bad++; $display("FAIL reset_awaddr got=%h exp=0", awaddr); end
        n_vec++; if (wb_ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_wb_ready1 got=%b exp=1", wb_ready1); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int edges; bit to;
        rnd_rdy = 1'b0; fill_buf();
        do_burst(26'h1234, edges, to);
        n_vec++; if (to) begin n_bad++; $display("FAIL basic_timeout got=busy exp=idle"); end
        n_vec++; if (edges != 10) begin n_bad++; $display("FAIL basic_latency got=%0d exp=10", edges); end
        n_vec++; if (!aw_at_accept) begin n_bad++; $display("FAIL basic_awvalid_next got=0 exp=1"); end
        n_vec++; if (aw_q.size() != 1 || aw_q[0] !== 32'h48D00) begin n_bad++; $display("FAIL basic_awaddr got=%h n=%0d exp=00048d00", aw_q.size() > 0 ? aw_q[0] : 32'hx, aw_q.size()); end
        n_vec++; if (len_q.size() != 1 || len_q[0] !== 8'd7) begin n_bad++; $display("FAIL basic_awlen got=%0d exp=7", len_q.size() > 0 ? len_q[0] : 8'hx); end
        n_vec++; if ({awsize, awburst, awcache, awid, awlock, awprot, awqos} !== {3'd3, 2'b01, 4'b0011, 1'b0, 1'b0, 3'd0, 4'd0})
            begin n_bad++; $display("FAIL basic_aw_consts got=%h", {awsize, awburst, awcache, awid, awlock, awprot, awqos}); end
        n_vec++; if (wstrb !== 8'hFF) begin n_bad++; $display("FAIL basic_wstrb got=%h exp=ff", wstrb); end
        n_vec++; if (wd_q.size() != 8) begin n_bad++; $display("FAIL basic_beats got=%0d exp=8", wd_q.size()); end
        for (int i = 0; i < 8 && i < wd_q.size(); i++) begin
            n_vec++; if (wd_q[i] !== bufm[i] || wl_q[i] != (i == 7))
                begin n_bad++; $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, wd_q[i], wl_q[i], bufm[i], i == 7); end
        end
        n_vec++; if (b_cnt != 1 || proto_bad != 0) begin n_bad++; $display("FAIL basic_b_proto got=%0d/%0d exp=1/0", b_cnt, proto_bad); end
    endtask

    task automatic test_wready_stall();
        int edges; bit to;
        rnd_rdy = 1'b0; fill_buf(); stall_beat = 3; stall_left = 2;
        do_burst(26'h2AB_CDEF, edges, to);
        stall_beat = -1;
        n_vec++; if (to || edges != 12) begin n_bad++; $display("FAIL stall_latency got=%0d exp=12", edges); end
        n_vec++; if (proto_bad != 0) begin n_bad++; $display("FAIL stall_stability got=%0d exp=0", proto_bad); end
        n_vec++; if (wd_q.size() != 8) begin n_bad++; $display("FAIL stall_beats got=%0d exp=8", wd_q.size()); end
        for (int i = 0; i < 8 && i < wd_q.size(); i++) begin
            n_vec++; if (wd_q[i] !== bufm[i]) begin n_bad++; $display("FAIL stall_beat%0d got=%h exp=%h", i, wd_q[i], bufm[i]); end
        end
    endtask

    task automatic test_aw_delay();
        int edges; bit to;
        rnd_rdy = 1'b0; fill_buf(); aw_delay_left = 5;
        do_burst(26'h0000_001, edges, to);
        n_vec++; if (to || edges != 15) begin n_bad++; $display("FAIL awdelay_latency got=%0d exp=15", edges); end
        n_vec++; if (proto_bad != 0) begin n_bad++; $display("FAIL awdelay_protocol got=%0d exp=0", proto_bad); end
        n_vec++; if (aw_q.size() != 1 || aw_q[0] !== 32'h40) begin n_bad++; $display("FAIL awdelay_awaddr got=%h exp=00000040", aw_q.size() > 0 ? aw_q[0] : 32'hx); end
    endtask

    task automatic test_retry();
        int edges; bit to; int nb;
`ifdef AXI_WRITE_RETRY_EN
        nb = 2;
`else
        nb = 1;
`endif
        rnd_rdy = 1'b0; fill_buf(); err_left = 1;
        do_burst(26'h3FF_FFFF, edges, to);
        n_vec++; if (to || edges != 10 * nb) begin n_bad++; $display("FAIL retry_latency got=%0d exp=%0d", edges, 10 * nb); end
        n_vec++; if (aw_q.size() != nb || b_cnt != nb) begin n_bad++; $display("FAIL retry_bursts got=%0d/%0d exp=%0d", aw_q.size(), b_cnt, nb); end
        for (int k = 0; k < aw_q.size(); k++) begin
            n_vec++; if (aw_q[k] !== 32'hFFFF_FFC0) begin n_bad++; $display("FAIL retry_awaddr%0d got=%h exp=ffffffc0", k, aw_q[k]); end
        end
        n_vec++; if (wd_q.size() != 8 * nb) begin n_bad++; $display("FAIL retry_beats got=%0d exp=%0d", wd_q.size(), 8 * nb); end
        for (int i = 0; i < wd_q.size() && i < 8 * nb; i++) begin
            n_vec++; if (wd_q[i] !== bufm[i % 8] || wl_q[i] != (i % 8 == 7))
                begin n_bad++; $display("FAIL retry_beat%0d got=%h exp=%h", i, wd_q[i], bufm[i % 8]); end
        end
    endtask

    task automatic test_random();
        int edges; bit to; int errs; int nb; logic [25:0] a; logic [31:0] ea;
        for (int it = 0; it < 8; it++) begin
            rnd_rdy = 1'b1; fill_buf();
            a = 26'($urandom); errs = $urandom_range(0, 1); err_left = errs;
            stall_beat = $urandom_range(0, 7); stall_left = $urandom_range(0, 3);
            ea = {a, 6'b000000};
`ifdef AXI_WRITE_RETRY_EN
            nb = 1 + errs;
`else
            nb = 1;
`endif
            do_burst(a, edges, to);
            n_vec++; if (to) begin n_bad++; $display("FAIL rand%0d_timeout got=busy exp=idle", it); end
            n_vec++; if (aw_q.size() != nb || wd_q.size() != 8 * nb || proto_bad != 0)
                begin n_bad++; $display("FAIL rand%0d_shape got=%0d/%0d/%0d exp=%0d/%0d/0", it, aw_q.size(), wd_q.size(), proto_bad, nb, 8 * nb); end
            for (int k = 0; k < aw_q.size(); k++) begin
                n_vec++; if (aw_q[k] !== ea || len_q[k] !== 8'd7) begin n_bad++; $display("FAIL rand%0d_aw got=%h exp=%h", it, aw_q[k], ea); end
            end
            for (int i = 0; i < wd_q.size() && i < 8 * nb; i++) begin
                n_vec++; if (wd_q[i] !== bufm[i % 8] || wl_q[i] != (i % 8 == 7))
                    begin n_bad++; $display("FAIL rand%0d_beat%0d got=%h exp=%h", it, i, wd_q[i], bufm[i % 8]); end
            end
        end
        rnd_rdy = 1'b0; stall_beat = -1; stall_left = 0; err_left = 0;
    endtask

    task automatic test_reset_midburst();
        int w = 0; int edges; bit to;
        rnd_rdy = 1'b0; fill_buf();
        wb_valid = 1'b1; wb_addr = 26'h155_5555;
        @(posedge clk); #1; wb_valid = 1'b0;
        while (!(wvalid && wb_word == 3'd4) && w < 50) begin @(posedge clk); #1; w++; end
        n_vec++; if (w >= 50) begin n_bad++; $display("FAIL rstmid_reach got=timeout exp=beat4"); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if ({wb_ready, awvalid, wvalid, bready} !== 4'b1000) begin n_bad++; $display("FAIL rstmid_ctrl got=%b exp=1000", {wb_ready, awvalid, wvalid, bready}); end
        n_vec++; if (wb_word !== 3'd0) begin n_bad++; $display("FAIL rstmid_wb_word got=%0d exp=0", wb_word); end
        @(posedge clk); #1; reset = 1'b0;
        do_burst(26'h000_0ABC, edges, to);
        n_vec++; if (to || edges != 10 || wd_q.size() != 8 || aw_q.size() != 1) begin n_bad++; $display("FAIL rstmid_recover got=%0d/%0d exp=10/8", edges, wd_q.size()); end
    endtask

    task automatic test_single_beat();
        int edges = 0; int beats = 0; logic [26:0] a; logic [31:0] ea;
        a = 27'($urandom); ea = {a, 5'b00000};
        for (int i = 0; i < 8; i++) buf1[i*32 +: 32] = $urandom;
        wb_valid1 = 1'b1; wb_addr1 = a;
        @(posedge clk); #1; wb_valid1 = 1'b0;
        n_vec++; if (awvalid1 !== 1'b1 || awaddr1 !== ea || awlen1 !== 8'd0)
            begin n_bad++; $display("FAIL single_aw got=%b/%h/%0d exp=1/%h/0", awvalid1, awaddr1, awlen1, ea); end
        while (!wb_ready1 && edges < 20) begin
            if (wvalid1) begin
                beats++;
                n_vec++; if (wlast1 !== 1'b1 || wdata1 !== buf1 || wb_word1 !== 1'b0)
                    begin n_bad++; $display("FAIL single_beat got=last%b word%0d exp=last1 word0", wlast1, wb_word1); end
            end
            @(posedge clk); #1; edges++;
        end
        n_vec++; if (beats != 1 || edges != 3) begin n_bad++; $display("FAIL single_count got=%0d/%0d exp=1/3", beats, edges); end
    endtask

    initial begin
        wb_valid = 1'b0; wb_addr = '0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; bid = 1'b1;
        wb_valid1 = 1'b0; wb_addr1 = '0; buf1 = '0;
        awready1 = 1'b1; wready1 = 1'b1; bvalid1 = 1'b1; bresp1 = 2'b00; bid1 = 1'b0;
        for (int i = 0; i < 8; i++) bufm[i] = '0;
        test_reset();
        test_basic();
        test_wready_stall();
        test_aw_delay();
        test_retry();
        test_random();
        test_reset_midburst();
        test_single_beat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
